edabk_transmitter_controller: RTL
=================================

// Module: edabk_transmitter_controller
// PURPOSE
//  UART TX sequencer; counterpart of the receiver controller in edabk_uart_transceiver.
//  - Accepts one DATA_WIDTH word per valid/ready handshake.
//  - Generates the oversample tick from bclk and serialises the frame: start, data LSB-first, optional parity, stop bit(s).
//  - Sits between the TX buffer/host interface and the serial TX pin.
// PARAMETERS
//  CLK_FREQ    `CFG_CLK_FREQ (50_000_000)  bclk frequency, Hz
//  CLK_DIV     `CFG_CLK_DIV (16)           oversample ticks per data bit
//  BAUDRATE    `CFG_BAUDRATE (115200)      line baud rate
//  DATA_WIDTH  `CFG_DATA_WIDTH (8)         data bits per frame, 5..9
//  STOP_BITS   1                           stop bits, 1 or 2
//  TICK_DIV    (CLK_FREQ*2/(CLK_DIV*BAUDRATE)+1)/2   bclk cycles per tick, rounded; elaboration error if <1
//  BAUD_WIDTH  $clog2(TICK_DIV)+1          tick counter width
// PORTS
//  bclk        in   1           clock
//  reset_n     in   1           asynchronous reset, active low
//  tx_valid    in   1           tx_data valid
//  tx_data     in   DATA_WIDTH  word to send
//  tx_ready    out  1           controller can accept a word
//  parity_en   in   1           1: insert parity bit
//  parity_odd  in   1           1: odd parity, 0: even
//  tx_busy     out  1           frame in progress
//  tx_done     out  1           1-cycle pulse, frame complete
//  tx_o        out  1           serial line, idle high
// BEHAVIOUR
//  - Reset (async, reset_n=0): tx_o=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, all counters 0.
//    Reset mid-frame aborts the frame; the line goes high immediately.
//  - Handshake: accept when tx_valid && tx_ready. tx_ready=1 only in IDLE.
//    On accept: latch tx_data, parity_en and parity_odd; clear tick and bit counters.
//    tx_valid while tx_ready=0 is ignored. Inputs changing mid-frame have no effect.
//  - Tick: counter counts 0..TICK_DIV-1 and pulses tick on wrap. Bit boundary = CLK_DIV ticks.
//    One bit = TICK_DIV*CLK_DIV bclk cycles.
//  - FSM transitions, each at a bit boundary:
//    IDLE -accept-> START; START -> DATA;
//    DATA -> PARITY if latched parity_en, else STOP, after DATA_WIDTH bits;
//    PARITY -> STOP; STOP -> IDLE after STOP_BITS bits.
//  - tx_o per state: START=0; DATA=shreg[0], with a right shift each bit boundary; PARITY=^data ^ parity_odd; STOP=1; IDLE=1.
//  - Latency: tx_o falls on the first cycle after the accept edge (registered output).
//  - tx_busy=1 from the cycle after accept until the end of the last stop bit.
//  - End of frame, same cycle: tx_done=1, tx_busy=0, tx_ready=1.
//    If tx_valid=1 then, the next word is accepted that cycle, giving zero idle gap.
//  - Frame length = (1+DATA_WIDTH+parity_en+STOP_BITS) bits.
//  - Bit counter width $clog2(DATA_WIDTH+1); it never wraps, and the count resets on every state change.
// STRUCTURE
//  - Package edabk_uart_pkg holds:
//    - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
//    - the TICK_DIV/BAUD_WIDTH helper functions.
//    The receiver controller shares both.
//  - Sub-module edabk_baud_tick_gen (TICK_DIV, BAUD_WIDTH): inputs bclk, reset_n, clr; output tick.
//    The same generator is reused by the receiver.
//  - FSM, shift register and bit counter stay in this module.
// TESTING
//  Bench params: CLK_FREQ=1_843_200, BAUDRATE=115200, CLK_DIV=16 -> TICK_DIV=1, 16 cycles/bit.
//  1. Reset, idle 20 cycles -> tx_o=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
//  2. Send 8'hA5, parity_en=0 -> tx_o bits 0,1,0,1,0,0,1,0,1,1, 16 cycles each.
//     tx_done pulses 160 cycles after accept.
//  3. Send 8'h03 with parity_en=1: even parity -> parity bit 0; odd -> 1. Frame 176 cycles.
//     Toggling parity_odd mid-frame has no effect.
//  4. tx_valid held high, words 8'h11 then 8'h22 -> second accepted in the tx_done cycle; no idle-high gap between frames.
//  5. Pulse tx_valid with 8'hFF during frame 1 -> ignored.
//     tx_ready=0 throughout; only the original frame is sent.
//  6. Assert reset_n=0 in DATA bit 3 -> tx_o=1 asynchronously.
//     After release: tx_ready=1, and the next accept starts a clean start bit of exactly 16 cycles.

Source files
------------

// File: rtl/edabk_uart_pkg.sv
// Shared UART definitions for the transmitter and receiver controllers.
//   tx_state_e      : frame sequencer states
//   calc_tick_div   : bclk cycles per oversample tick, rounded to nearest
//   calc_baud_width : width of the tick counter for a given tick divider
package edabk_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    function automatic int calc_tick_div(int clk_freq, int clk_div, int baudrate);
        longint num;
        longint den;
        num = longint'(clk_freq) * 64'sd2;
        den = longint'(clk_div) * longint'(baudrate);
        // (2*f/d + 1)/2 rounds to nearest without floating point
        return int'((num / den + 64'sd1) / 64'sd2);
    endfunction

    function automatic int calc_baud_width(int tick_div);
        return $clog2(tick_div) + 1;
    endfunction

endpackage

// File: rtl/edabk_baud_tick_gen.sv
// Oversample tick generator: counts bclk cycles 0..TICK_DIV-1 and flags the
// wrap cycle. Shared by the TX and RX controllers.
//   bclk    in  clock
//   reset_n in  asynchronous reset, active low
//   clr     in  restart the count (frame start alignment)
//   tick    out high on the last cycle of each tick period
module edabk_baud_tick_gen #(
    parameter int TICK_DIV   = 1,
    parameter int BAUD_WIDTH = 1
) (
    input  logic bclk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam logic [BAUD_WIDTH-1:0] LAST = BAUD_WIDTH'(TICK_DIV - 1);

    logic [BAUD_WIDTH-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n)          cnt <= '0;
        else if (clr || tick)  cnt <= '0;
        else                   cnt <= cnt + BAUD_WIDTH'(1);
    end

endmodule

// File: rtl/edabk_transmitter_controller.sv
// UART TX sequencer: takes one word per valid/ready handshake and serialises
// start, data (LSB first), optional parity and stop bit(s) onto tx_o.
//   bclk, reset_n         clock, async active-low reset
//   tx_valid/tx_data      word offered by the host, tx_ready accepts it
//   parity_en, parity_odd parity control, sampled at accept
//   tx_busy               frame in progress
//   tx_done               one-cycle pulse when the frame has completed
//   tx_o                  registered serial line, idle high
`ifndef CFG_CLK_FREQ
`define CFG_CLK_FREQ 50_000_000
`endif
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_BAUDRATE
`define CFG_BAUDRATE 115200
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_transmitter_controller
    import edabk_uart_pkg::*;
#(
    parameter int CLK_FREQ   = `CFG_CLK_FREQ,
    parameter int CLK_DIV    = `CFG_CLK_DIV,
    parameter int BAUDRATE   = `CFG_BAUDRATE,
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int STOP_BITS  = 1,
    parameter int TICK_DIV   = calc_tick_div(CLK_FREQ, CLK_DIV, BAUDRATE),
    parameter int BAUD_WIDTH = calc_baud_width(TICK_DIV)
) (
    input  logic                  bclk,
    input  logic                  reset_n,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_o
);

    if (TICK_DIV < 1) begin : g_bad_tick
        $error("TICK_DIV must be at least 1");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("DATA_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int OS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [OS_W-1:0]  LAST_OS   = OS_W'(CLK_DIV - 1);

    tx_state_e             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en;
    logic                  par_bit;
    logic [OS_W-1:0]       os_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  tick;
    logic                  accept;

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    // Restart the tick phase on accept so every bit is exactly
    // TICK_DIV*CLK_DIV cycles measured from the accept edge.
    edabk_baud_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .BAUD_WIDTH (BAUD_WIDTH)
    ) u_tick (
        .bclk    (bclk),
        .reset_n (reset_n),
        .clr     (accept),
        .tick    (tick)
    );

    // tx_o is driven with the value of the state being entered, so the line
    // changes on the same edge as the state and no output mux is needed.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            os_cnt  <= '0;
            bit_cnt <= '0;
            tx_o    <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (accept) begin
                state   <= START;
                shreg   <= tx_data;
                par_en  <= parity_en;
                // even: bit makes the ones count even; odd inverts it
                par_bit <= (^tx_data) ^ parity_odd;
                os_cnt  <= '0;
                bit_cnt <= '0;
                tx_o    <= 1'b0;
            end else if (tx_busy && tick) begin
                if (os_cnt != LAST_OS) begin
                    os_cnt <= os_cnt + OS_W'(1);
                end else begin
                    os_cnt <= '0;
                    case (state)
                        START: begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            tx_o    <= shreg[0];
                        end
                        DATA: begin
                            if (bit_cnt == LAST_DATA) begin
                                state   <= par_en ? PARITY : STOP;
                                bit_cnt <= '0;
                                tx_o    <= par_en ? par_bit : 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                shreg   <= shreg >> 1;
                                tx_o    <= shreg[1];
                            end
                        end
                        PARITY: begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            tx_o    <= 1'b1;
                        end
                        STOP: begin
                            if (bit_cnt == LAST_STOP) begin
                                state   <= IDLE;
                                bit_cnt <= '0;
                                tx_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                            tx_o <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                            tx_o  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule
